// File: rtl/code_lock_n.sv
// N-digit code lock: digit entry buffer, code check with consecutive-failure
// lockout, and a two-pass verified code change. All outputs are registered.
module code_lock_n #(
  parameter int DIGITS      = 4,
  parameter int MAX_ERR     = 3,
  parameter int LOCKOUT_CYC = 50000000,
  parameter logic [DIGITS*4-1:0] DEFAULT_CODE = 16'h1234
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          digit_in,
  input  logic                digit_we,
  input  logic                confirm,
  input  logic                clear,
  input  logic                lock,
  input  logic                change_req,
  output logic [DIGITS*4-1:0] entry,
  output logic [3:0]          entry_cnt,
  output logic                unlocked,
  output logic                locked_out,
  output logic [3:0]          err_cnt,
  output logic                ok_pulse,
  output logic                fail_pulse,
  output logic [2:0]          state
);

  localparam int W  = DIGITS * 4;
  localparam int CW = (LOCKOUT_CYC > 2) ? $clog2(LOCKOUT_CYC) : 1;

  typedef enum logic [2:0] {
    S_LOCKED     = 3'd0,
    S_UNLOCKED   = 3'd1,
    S_CHG_NEW    = 3'd2,
    S_CHG_VERIFY = 3'd3,
    S_LOCKOUT    = 3'd4
  } state_t;

  // Input pulses are single-cycle strobes with no back-pressure: each is acted
  // on in the cycle it is high, and its response is visible one cycle later.
  state_t         state_q, state_n;
  logic [W-1:0]   entry_q, entry_n;
  logic [W-1:0]   code_q, code_n;
  logic [W-1:0]   pend_q, pend_n;
  logic [3:0]     cnt_q, cnt_n;
  logic [3:0]     err_q, err_n;
  logic [CW-1:0]  lo_q, lo_n;
  logic           ok_q, ok_n;
  logic           fail_q, fail_n;
  logic           unl_q, unl_n;
  logic           lko_q, lko_n;

  logic full, digit_ok, code_match, pend_match;

  always_comb begin
    full       = (cnt_q == 4'(DIGITS));
    digit_ok   = digit_we && (digit_in <= 4'd9) && !full;
    code_match = full && (entry_q == code_q);
    pend_match = full && (entry_q == pend_q);
  end

  always_comb begin
    state_n = state_q;
    entry_n = entry_q;
    cnt_n   = cnt_q;
    code_n  = code_q;
    pend_n  = pend_q;
    err_n   = err_q;
    lo_n    = lo_q;
    ok_n    = 1'b0;
    fail_n  = 1'b0;

    case (state_q)
      S_LOCKOUT: begin
        entry_n = '0;
        cnt_n   = '0;
        if (lo_q == '0) begin
          err_n   = '0;
          state_n = S_LOCKED;
        end else begin
          lo_n = lo_q - 1'b1;
        end
      end

      S_UNLOCKED: begin
        if (lock || change_req) begin
          entry_n = '0;
          cnt_n   = '0;
          state_n = lock ? S_LOCKED : S_CHG_NEW;
        end else if (clear || confirm) begin
          entry_n = '0;
          cnt_n   = '0;
        end else if (digit_ok) begin
          entry_n = {entry_q[W-5:0], digit_in};
          cnt_n   = cnt_q + 4'd1;
        end
      end

      S_LOCKED, S_CHG_NEW, S_CHG_VERIFY: begin
        if (clear) begin
          entry_n = '0;
          cnt_n   = '0;
        end else if (confirm) begin
          entry_n = '0;
          cnt_n   = '0;
          if (state_q == S_LOCKED) begin
            if (code_match) begin
              ok_n    = 1'b1;
              err_n   = '0;
              state_n = S_UNLOCKED;
            end else begin
              fail_n = 1'b1;
              if (err_q < 4'(MAX_ERR)) err_n = err_q + 4'd1;
              // Lockout trips on the attempt that brings the count to the limit.
              if (err_q + 4'd1 == 4'(MAX_ERR)) begin
                state_n = S_LOCKOUT;
                lo_n    = CW'(LOCKOUT_CYC - 1);
              end
            end
          end else if (state_q == S_CHG_NEW) begin
            if (full) begin
              pend_n  = entry_q;
              state_n = S_CHG_VERIFY;
            end else begin
              fail_n  = 1'b1;
              state_n = S_UNLOCKED;
            end
          end else begin
            if (pend_match) begin
              code_n = pend_q;
              ok_n   = 1'b1;
            end else begin
              fail_n = 1'b1;
            end
            state_n = S_UNLOCKED;
          end
        end else if (digit_ok) begin
          entry_n = {entry_q[W-5:0], digit_in};
          cnt_n   = cnt_q + 4'd1;
        end
      end

      default: begin
        entry_n = '0;
        cnt_n   = '0;
        state_n = S_LOCKED;
      end
    endcase

    unl_n = (state_n == S_UNLOCKED) || (state_n == S_CHG_NEW) ||
            (state_n == S_CHG_VERIFY);
    lko_n = (state_n == S_LOCKOUT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_LOCKED;
      entry_q <= '0;
      cnt_q   <= '0;
      code_q  <= DEFAULT_CODE;
      pend_q  <= '0;
      err_q   <= '0;
      lo_q    <= '0;
      ok_q    <= 1'b0;
      fail_q  <= 1'b0;
      unl_q   <= 1'b0;
      lko_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      entry_q <= entry_n;
      cnt_q   <= cnt_n;
      code_q  <= code_n;
      pend_q  <= pend_n;
      err_q   <= err_n;
      lo_q    <= lo_n;
      ok_q    <= ok_n;
      fail_q  <= fail_n;
      unl_q   <= unl_n;
      lko_q   <= lko_n;
    end
  end

  assign entry      = entry_q;
  assign entry_cnt  = cnt_q;
  assign unlocked   = unl_q;
  assign locked_out = lko_q;
  assign err_cnt    = err_q;
  assign ok_pulse   = ok_q;
  assign fail_pulse = fail_q;
  assign state      = state_q;

endmodule

// File: tb/tb_code_lock_n.sv
// Bench for code_lock_n: directed walk through the main flows, then random
// pulses, all checked every cycle against a digit-queue reference model.
module tb_code_lock_n;

  localparam int DIGITS      = 4;
  localparam int MAX_ERR     = 3;
  localparam int LOCKOUT_CYC = 20;
  localparam int W           = DIGITS * 4;
  localparam logic [W-1:0] DEFAULT_CODE = 16'h1234;

  localparam int M_LOCKED = 0, M_UNLOCKED = 1, M_CHG_NEW = 2, M_CHG_VERIFY = 3,
                 M_LOCKOUT = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   digit_in = '0;
  logic         digit_we = 1'b0, confirm = 1'b0, clear = 1'b0;
  logic         lock = 1'b0, change_req = 1'b0;
  logic [W-1:0] entry;
  logic [3:0]   entry_cnt, err_cnt;
  logic         unlocked, locked_out, ok_pulse, fail_pulse;
  logic [2:0]   state;

  int n_checks = 0;
  int n_fail   = 0;

  code_lock_n #(
    .DIGITS(DIGITS), .MAX_ERR(MAX_ERR), .LOCKOUT_CYC(LOCKOUT_CYC),
    .DEFAULT_CODE(DEFAULT_CODE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .digit_in(digit_in), .digit_we(digit_we),
    .confirm(confirm), .clear(clear), .lock(lock), .change_req(change_req),
    .entry(entry), .entry_cnt(entry_cnt), .unlocked(unlocked),
    .locked_out(locked_out), .err_cnt(err_cnt), .ok_pulse(ok_pulse),
    .fail_pulse(fail_pulse), .state(state)
  );

  always #5 clk = ~clk;

  // Reference model: entry is a queue of digits, codes are plain integers.
  int m_state, m_code, m_pend, m_err, m_left;
  int m_entry[$];
  bit m_ok, m_fail;

  function automatic int entry_val();
    int v = 0;
    foreach (m_entry[i]) v = v * 16 + m_entry[i];
    return v;
  endfunction

  function automatic int code_digit(input int code, input int pos);
    return (code >> (4 * (DIGITS - 1 - pos))) & 15;
  endfunction

  task automatic model_step(input int d, input bit we, cf, clr, lk, chg, r);
    bit complete;
    int val;
    if (!r) begin
      m_state = M_LOCKED; m_code = int'(DEFAULT_CODE); m_pend = 0;
      m_err = 0; m_left = 0; m_ok = 0; m_fail = 0;
      m_entry.delete();
      return;
    end
    m_ok = 0; m_fail = 0;
    complete = (m_entry.size() == DIGITS);
    val = entry_val();
    if (m_state == M_LOCKOUT) begin
      m_left--;
      if (m_left == 0) begin m_state = M_LOCKED; m_err = 0; end
    end else if (m_state == M_UNLOCKED && (lk || chg)) begin
      m_entry.delete();
      m_state = lk ? M_LOCKED : M_CHG_NEW;
    end else if (clr) begin
      m_entry.delete();
    end else if (cf) begin
      m_entry.delete();
      case (m_state)
        M_LOCKED: begin
          if (complete && val == m_code) begin
            m_ok = 1; m_err = 0; m_state = M_UNLOCKED;
          end else begin
            m_fail = 1;
            if (m_err < MAX_ERR) m_err++;
            if (m_err == MAX_ERR) begin m_state = M_LOCKOUT; m_left = LOCKOUT_CYC; end
          end
        end
        M_CHG_NEW: begin
          if (complete) begin m_pend = val; m_state = M_CHG_VERIFY; end
          else begin m_fail = 1; m_state = M_UNLOCKED; end
        end
        M_CHG_VERIFY: begin
          if (complete && val == m_pend) begin m_code = m_pend; m_ok = 1; end
          else m_fail = 1;
          m_state = M_UNLOCKED;
        end
        default: ;
      endcase
    end else if (we && d <= 9 && !complete) begin
      m_entry.push_back(d);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("state", 32'(state), 32'(m_state));
    check("entry", 32'(entry), 32'(entry_val()));
    check("entry_cnt", 32'(entry_cnt), 32'(m_entry.size()));
    check("unlocked", 32'(unlocked),
          32'(m_state == M_UNLOCKED || m_state == M_CHG_NEW || m_state == M_CHG_VERIFY));
    check("locked_out", 32'(locked_out), 32'(m_state == M_LOCKOUT));
    check("err_cnt", 32'(err_cnt), 32'(m_err));
    check("ok_pulse", 32'(ok_pulse), 32'(m_ok));
    check("fail_pulse", 32'(fail_pulse), 32'(m_fail));
  endtask

  // One clock: drive pulses, let the edge happen, step the model, compare.
  task automatic cycle(input logic [3:0] d, input bit we, cf, clr, lk, chg, r);
    digit_in = d; digit_we = we; confirm = cf; clear = clr;
    lock = lk; change_req = chg; rst_n = r;
    @(posedge clk);
    model_step(int'(d), we, cf, clr, lk, chg, r);
    #1;
    check_all();
    digit_we = 0; confirm = 0; clear = 0; lock = 0; change_req = 0;
  endtask

  task automatic idle();           cycle(4'd0, 0, 0, 0, 0, 0, 1); endtask
  task automatic key(input logic [3:0] d); cycle(d, 1, 0, 0, 0, 0, 1); endtask
  task automatic do_confirm();     cycle(4'd0, 0, 1, 0, 0, 0, 1); endtask
  task automatic do_lock();        cycle(4'd0, 0, 0, 0, 1, 0, 1); endtask
  task automatic do_change();      cycle(4'd0, 0, 0, 0, 0, 1, 1); endtask
  task automatic do_reset();       cycle(4'd0, 0, 0, 0, 0, 0, 0); endtask

  task automatic enter(input logic [15:0] code);
    for (int i = 3; i >= 0; i--) key(code[i*4 +: 4]);
  endtask

  initial begin
    do_reset(); do_reset();
    check("reset_state", 32'(state), 32'd0);
    check("reset_entry", 32'(entry), 32'd0);

    enter(16'h1234); do_confirm();
    check("open_ok", 32'(ok_pulse), 32'd1);
    check("open_state", 32'(state), 32'd1);
    idle();
    check("open_ok_drop", 32'(ok_pulse), 32'd0);
    do_lock();

    for (int k = 1; k <= 3; k++) begin
      enter(16'h1235); do_confirm();
      check("wrong_fail", 32'(fail_pulse), 32'd1);
      check("wrong_err", 32'(err_cnt), 32'(k));
    end
    check("lockout_enter", 32'(state), 32'd4);
    for (int i = 1; i < LOCKOUT_CYC; i++) begin
      cycle(4'($urandom_range(0, 9)), 1, ($urandom_range(0, 3) == 0), 0, 1, 1, 1);
      check("lockout_hold", 32'(state), 32'd4);
    end
    idle();
    check("lockout_exit", 32'(state), 32'd0);
    check("lockout_err0", 32'(err_cnt), 32'd0);

    enter(16'h1234); key(4'd5);
    check("no_wrap_entry", 32'(entry), 32'h1234);
    check("no_wrap_cnt", 32'(entry_cnt), 32'd4);
    key(4'hA);
    check("bad_digit", 32'(entry), 32'h1234);
    cycle(4'd0, 0, 1, 1, 0, 0, 1);
    check("clr_cf_entry", 32'(entry), 32'd0);
    check("clr_cf_pulses", 32'({ok_pulse, fail_pulse}), 32'd0);

    enter(16'h1234); do_confirm();
    do_change(); enter(16'h9876); do_confirm();
    check("chg_verify_state", 32'(state), 32'd3);
    enter(16'h9876); do_confirm();
    check("chg_ok", 32'(ok_pulse), 32'd1);
    do_lock(); enter(16'h1234); do_confirm();
    check("old_code_fail", 32'(fail_pulse), 32'd1);
    enter(16'h9876); do_confirm();
    check("new_code_open", 32'(unlocked), 32'd1);

    do_reset();
    enter(16'h1234); do_confirm();
    do_change(); enter(16'h9876); do_confirm(); enter(16'h9877); do_confirm();
    check("chg_mismatch", 32'(fail_pulse), 32'd1);
    check("chg_err_kept", 32'(err_cnt), 32'd0);
    do_lock(); enter(16'h1234); do_confirm();
    check("code_unchanged", 32'(state), 32'd1);
    do_change(); enter(16'h5555); do_confirm();
    do_reset();
    check("rst_mid_change", 32'(state), 32'd0);
    enter(16'h1234); do_confirm();
    check("default_after_rst", 32'(state), 32'd1);
    do_lock();

    key(4'd1); key(4'd2); do_confirm();
    check("short_fail", 32'(fail_pulse), 32'd1);
    check("short_err", 32'(err_cnt), 32'd1);
    enter(16'h1234); do_confirm();
    check("err_cleared", 32'(err_cnt), 32'd0);

    for (int n = 0; n < 4000; n++) begin
      logic [3:0] d;
      int pos, tgt;
      pos = m_entry.size();
      tgt = (m_state == M_CHG_VERIFY) ? m_pend : m_code;
      if (pos < DIGITS && $urandom_range(0, 9) < 7) d = 4'(code_digit(tgt, pos));
      else d = 4'($urandom_range(0, 11));
      cycle(d, ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 15),
            ($urandom_range(0, 99) < 4), ($urandom_range(0, 99) < 5),
            ($urandom_range(0, 99) < 8), ($urandom_range(0, 299) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
